key_sw_conditioner: RTL and testbench

Input conditioning stage directly upstream of the Qsys system's `keys_export[3:0]` and `sw_export[9:0]` PIO inputs. It takes the raw asynchronous board pushbuttons (active-low) and slide switches and synchronises each bit into `clk_clk`. It debounces each bit and drives clean levels into the PIOs. It also produces one-cycle press/release strobes for the keys, which the top level routes to LEDs or interrupt logic.

---
 rtl/conditioner_pkg.sv | 18 +
 rtl/debounce_bit.sv | 76 +++++++
 rtl/key_sw_conditioner.sv | 48 ++++
 tb/tb_key_sw_conditioner.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/conditioner_pkg.sv
// rtl/conditioner_pkg.sv - shared constants and helpers for key/switch input conditioning
package conditioner_pkg;

    localparam int   DEBOUNCE_20MS_50MHZ = 1_000_000;
    localparam logic KEY_IDLE            = 1'b1;
    localparam logic SW_IDLE             = 1'b0;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } db_state_t;

    // Counter must hold 0..cycles-1; never narrower than one bit.
    function automatic int cnt_width(input int cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// rtl/debounce_bit.sv - one-bit synchronizer, debouncer and edge strobe generator
module debounce_bit
    import conditioner_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = DEBOUNCE_20MS_50MHZ,
    parameter logic IDLE_LEVEL      = 1'b0
) (
    input  logic clk_clk,
    input  logic reset_reset,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1, s2, stable;
    logic [CNT_W-1:0] cnt;
    db_state_t        state, next_state;

    logic             accept;
    logic             stable_d, rise_d, fall_d;
    logic [CNT_W-1:0] cnt_d;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            s1     <= IDLE_LEVEL;
            s2     <= IDLE_LEVEL;
            stable <= IDLE_LEVEL;
            cnt    <= '0;
            state  <= ST_IDLE;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            s1     <= raw;
            s2     <= s1;
            stable <= stable_d;
            cnt    <= cnt_d;
            state  <= next_state;
            rise   <= rise_d;
            fall   <= fall_d;
        end
    end

    // State tracks whether s2 will differ from the accepted level after this edge.
    always_comb begin
        next_state = ST_IDLE;
        if (s1 != stable_d)
            next_state = ST_PENDING;
    end

    always_comb begin
        accept   = 1'b0;
        stable_d = stable;
        cnt_d    = '0;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        if (state == ST_PENDING) begin
            if (s2 != stable && cnt == CNT_LAST) begin
                accept   = 1'b1;
                stable_d = s2;
                rise_d   = s2;
                fall_d   = ~s2;
            end else if (s2 != stable) begin
                cnt_d = cnt + 1'b1;
            end
        end
        if (accept)
            cnt_d = '0;
    end

    assign level = stable;

endmodule

// File: rtl/key_sw_conditioner.sv
// rtl/key_sw_conditioner.sv - debounced key/switch levels and key press/release strobes
module key_sw_conditioner
    import conditioner_pkg::*;
#(
    parameter int N_KEYS          = 4,
    parameter int N_SW            = 10,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_20MS_50MHZ
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic [N_KEYS-1:0] key_raw,
    input  logic [N_SW-1:0]   sw_raw,
    output logic [N_KEYS-1:0] keys_db,
    output logic [N_SW-1:0]   sw_db,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release
);

    // Keys are active-low: a falling debounced level is a press.
    for (genvar i = 0; i < N_KEYS; i++) begin : g_key
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .IDLE_LEVEL      (KEY_IDLE)
        ) u_db (
            .clk_clk     (clk_clk),
            .reset_reset (reset_reset),
            .raw         (key_raw[i]),
            .level       (keys_db[i]),
            .rise        (key_release[i]),
            .fall        (key_press[i])
        );
    end

    for (genvar j = 0; j < N_SW; j++) begin : g_sw
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .IDLE_LEVEL      (SW_IDLE)
        ) u_db (
            .clk_clk     (clk_clk),
            .reset_reset (reset_reset),
            .raw         (sw_raw[j]),
            .level       (sw_db[j]),
            .rise        (),
            .fall        ()
        );
    end

endmodule

// File: tb/tb_key_sw_conditioner.sv
// tb/tb_key_sw_conditioner.sv - directed self-checking bench for key_sw_conditioner
module tb_key_sw_conditioner;

    localparam int NK = 4;
    localparam int NS = 10;
    localparam int DB = 8;

    logic          clk_clk = 1'b0;
    logic          reset_reset;
    logic [NK-1:0] key_raw;
    logic [NS-1:0] sw_raw;
    logic [NK-1:0] keys_db;
    logic [NS-1:0] sw_db;
    logic [NK-1:0] key_press;
    logic [NK-1:0] key_release;

    int errors = 0;
    int checks = 0;

    key_sw_conditioner #(
        .N_KEYS          (NK),
        .N_SW            (NS),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk_clk     (clk_clk),
        .reset_reset (reset_reset),
        .key_raw     (key_raw),
        .sw_raw      (sw_raw),
        .keys_db     (keys_db),
        .sw_db       (sw_db),
        .key_press   (key_press),
        .key_release (key_release)
    );

    always #5 clk_clk = ~clk_clk;

    // Advance one edge; inputs change and outputs are sampled 1 time unit later.
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk_clk);
            #1;
        end
    endtask

    task automatic test_reset;
        reset_reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            key_raw = 4'($urandom);
            sw_raw  = 10'($urandom);
            tick(1);
            checks++;
            if (keys_db !== 4'hF || sw_db !== 10'h000 || key_press !== 4'h0 || key_release !== 4'h0) begin
                errors++;
                $display("FAIL reset_values: keys_db=%h sw_db=%h press=%h release=%h, want F 000 0 0",
                         keys_db, sw_db, key_press, key_release);
            end
        end
        key_raw     = 4'hF;
        sw_raw      = '0;
        reset_reset = 1'b0;
        tick(3);
    endtask

    task automatic test_clean_press;
        key_raw[0] = 1'b0;
        for (int e = 1; e <= 11; e++) begin
            tick(1);
            checks++;
            if (e == 10) begin
                if (keys_db !== 4'b1110 || key_press !== 4'b0001 || key_release !== 4'b0000) begin
                    errors++;
                    $display("FAIL clean_press_edge10: keys_db=%b press=%b release=%b, want 1110 0001 0000",
                             keys_db, key_press, key_release);
                end
            end else if (e < 10) begin
                if (keys_db !== 4'b1111 || key_press !== 4'b0000) begin
                    errors++;
                    $display("FAIL clean_press_early e%0d: keys_db=%b press=%b, want 1111 0000", e, keys_db, key_press);
                end
            end else begin
                if (keys_db !== 4'b1110 || key_press !== 4'b0000) begin
                    errors++;
                    $display("FAIL clean_press_edge11: keys_db=%b press=%b, want 1110 0000", keys_db, key_press);
                end
            end
        end
        key_raw[0] = 1'b1;
        tick(9);
        checks++;
        if (keys_db !== 4'b1110 || key_release !== 4'b0000) begin
            errors++;
            $display("FAIL clean_release_early: keys_db=%b release=%b, want 1110 0000", keys_db, key_release);
        end
        tick(1);
        checks++;
        if (keys_db !== 4'b1111 || key_release !== 4'b0001 || key_press !== 4'b0000) begin
            errors++;
            $display("FAIL clean_release_edge10: keys_db=%b release=%b press=%b, want 1111 0001 0000",
                     keys_db, key_release, key_press);
        end
        tick(1);
        checks++;
        if (key_release !== 4'b0000) begin
            errors++;
            $display("FAIL clean_release_width: release=%b, want 0000", key_release);
        end
    endtask

    task automatic test_bounce;
        int bad = 0;
        for (int seg = 0; seg < 10; seg++) begin
            key_raw[1] = seg[0];
            for (int c = 0; c < 3; c++) begin
                tick(1);
                if (keys_db !== 4'hF || key_press !== 4'h0 || key_release !== 4'h0) bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bounce_quiet: %0d cycles with output change, want 0", bad);
        end
        key_raw[1] = 1'b0;
        tick(9);
        checks++;
        if (keys_db !== 4'b1111 || key_press !== 4'b0000) begin
            errors++;
            $display("FAIL bounce_early: keys_db=%b press=%b, want 1111 0000", keys_db, key_press);
        end
        tick(1);
        checks++;
        if (keys_db !== 4'b1101 || key_press !== 4'b0010) begin
            errors++;
            $display("FAIL bounce_settle: keys_db=%b press=%b, want 1101 0010", keys_db, key_press);
        end
        tick(1);
        checks++;
        if (key_press !== 4'b0000) begin
            errors++;
            $display("FAIL bounce_single_strobe: press=%b, want 0000", key_press);
        end
        key_raw[1] = 1'b1;
        tick(12);
    endtask

    task automatic test_glitch;
        int bad = 0;
        sw_raw[5] = 1'b1;
        for (int c = 0; c < 7; c++) begin
            tick(1);
            if (sw_db !== 10'h000) bad++;
        end
        sw_raw[5] = 1'b0;
        for (int c = 0; c < 15; c++) begin
            tick(1);
            if (sw_db !== 10'h000) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL glitch_7: sw_db changed in %0d cycles, want 0", bad);
        end
        sw_raw[5] = 1'b1;
        tick(8);
        sw_raw[5] = 1'b0;
        tick(1);
        checks++;
        if (sw_db !== 10'h000) begin
            errors++;
            $display("FAIL glitch_8_early: sw_db=%h, want 000", sw_db);
        end
        tick(1);
        checks++;
        if (sw_db !== 10'h020) begin
            errors++;
            $display("FAIL glitch_8_accept: sw_db=%h, want 020", sw_db);
        end
        tick(12);
        checks++;
        if (sw_db !== 10'h000) begin
            errors++;
            $display("FAIL glitch_8_return: sw_db=%h, want 000", sw_db);
        end
    endtask

    task automatic test_simultaneous;
        key_raw = 4'b0000;
        tick(9);
        checks++;
        if (key_press !== 4'b0000 || keys_db !== 4'b1111) begin
            errors++;
            $display("FAIL simul_early: press=%b keys_db=%b, want 0000 1111", key_press, keys_db);
        end
        tick(1);
        checks++;
        if (key_press !== 4'b1111 || keys_db !== 4'b0000 || key_release !== 4'b0000) begin
            errors++;
            $display("FAIL simul_press: press=%b keys_db=%b release=%b, want 1111 0000 0000",
                     key_press, keys_db, key_release);
        end
        key_raw = 4'b1111;
        tick(10);
        checks++;
        if (key_release !== 4'b1111 || keys_db !== 4'b1111 || key_press !== 4'b0000) begin
            errors++;
            $display("FAIL simul_release: release=%b keys_db=%b press=%b, want 1111 1111 0000",
                     key_release, keys_db, key_press);
        end
        tick(1);
        checks++;
        if (key_release !== 4'b0000) begin
            errors++;
            $display("FAIL simul_release_width: release=%b, want 0000", key_release);
        end
    endtask

    task automatic test_reset_mid_pending;
        int bad = 0;
        key_raw[2] = 1'b0;
        tick(7);
        reset_reset = 1'b1;
        tick(1);
        reset_reset = 1'b0;
        checks++;
        if (keys_db !== 4'b1111 || key_press !== 4'b0000) begin
            errors++;
            $display("FAIL midreset_in_reset: keys_db=%b press=%b, want 1111 0000", keys_db, key_press);
        end
        for (int e = 1; e <= 9; e++) begin
            tick(1);
            if (keys_db !== 4'b1111 || key_press !== 4'b0000 || key_release !== 4'b0000) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL midreset_no_old_deadline: %0d bad cycles, want 0", bad);
        end
        tick(1);
        checks++;
        if (keys_db !== 4'b1011 || key_press !== 4'b0100) begin
            errors++;
            $display("FAIL midreset_press: keys_db=%b press=%b, want 1011 0100", keys_db, key_press);
        end
        tick(1);
        checks++;
        if (key_press !== 4'b0000) begin
            errors++;
            $display("FAIL midreset_single: press=%b, want 0000", key_press);
        end
        key_raw[2] = 1'b1;
        tick(12);
    endtask

    initial begin
        reset_reset = 1'b1;
        key_raw     = 4'hF;
        sw_raw      = '0;
        tick(1);
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_simultaneous();
        test_reset_mid_pending();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
